// File: rtl/ov7670_frame_capture.sv
// OV7670 byte-stream to RGB332 frame-buffer writer: assembles two-byte pixels, clips them to the
// stored frame, drives the RAM write port and keeps frame count plus sticky error status.
module ov7670_frame_capture #(
    parameter int SCREEN_WIDTH  = 176,
    parameter int SCREEN_HEIGHT = 144,
    parameter int ADDR_W        = 15,
    parameter int FCNT_W        = 8
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              EN,
    input  logic [1:0]        MODE,
    input  logic              VSYNC,
    input  logic              HREF,
    input  logic [7:0]        DATA,
    input  logic              CLEAR,
    output logic [7:0]        PIXEL_OUT,
    output logic [ADDR_W-1:0] W_ADDR,
    output logic              W_EN,
    output logic              FRAME_DONE,
    output logic [FCNT_W-1:0] FRAME_COUNT,
    output logic [2:0]        STATUS
);

    localparam int X_W = $clog2(SCREEN_WIDTH + 1);
    localparam int Y_W = $clog2(SCREEN_HEIGHT + 1);

    localparam logic [X_W-1:0] X_MAX  = X_W'(SCREEN_WIDTH);
    localparam logic [Y_W-1:0] Y_MAX  = Y_W'(SCREEN_HEIGHT);
    localparam logic [X_W-1:0] BAR1_X = X_W'(SCREEN_WIDTH / 3);
    localparam logic [X_W-1:0] BAR2_X = X_W'((2 * SCREEN_WIDTH) / 3);

    localparam logic [1:0] WAIT_VS = 2'd0;
    localparam logic [1:0] WAIT_FS = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;

    localparam logic PHASE_HI = 1'b0;
    localparam logic PHASE_LO = 1'b1;

    logic [1:0]        state_reg,     state_next;
    logic [1:0]        mode_reg,      mode_next;
    logic [X_W-1:0]    x_reg,         x_next;
    logic [Y_W-1:0]    y_reg,         y_next;
    logic              phase_reg,     phase_next;
    logic [6:0]        hi_reg,        hi_next;
    logic              href_prev_reg, href_prev_next;
    logic [7:0]        pixel_reg,     pixel_next;
    logic [ADDR_W-1:0] addr_reg,      addr_next;
    logic              wen_reg,       wen_next;
    logic              done_reg,      done_next;
    logic [FCNT_W-1:0] fcount_reg,    fcount_next;
    logic [2:0]        status_reg,    status_next;

    logic [2:0]        set_bits;
    logic [7:0]        pix_conv;
    logic [ADDR_W-1:0] addr_calc;

    // hi_reg keeps only HI bits used by some format: {HI[7:5], HI[3:0]}
    always_comb begin
        case (mode_reg)
            2'd1:    pix_conv = {hi_reg[3:1], DATA[7:5], DATA[3:2]};
            2'd2: begin
                if (x_reg < BAR1_X)      pix_conv = 8'hE0;
                else if (x_reg < BAR2_X) pix_conv = 8'h1C;
                else                     pix_conv = 8'h03;
            end
            default: pix_conv = {hi_reg[6:4], hi_reg[2:0], DATA[4:3]};
        endcase
    end

    assign addr_calc = ADDR_W'(x_reg) + ADDR_W'(y_reg) * ADDR_W'(SCREEN_WIDTH);

    always_comb begin
        state_next     = state_reg;
        mode_next      = mode_reg;
        x_next         = x_reg;
        y_next         = y_reg;
        phase_next     = phase_reg;
        hi_next        = hi_reg;
        href_prev_next = href_prev_reg;
        pixel_next     = pixel_reg;
        addr_next      = addr_reg;
        wen_next       = 1'b0;
        done_next      = 1'b0;
        fcount_next    = fcount_reg;
        set_bits       = 3'b000;

        case (state_reg)
            WAIT_VS: begin
                if (VSYNC) state_next = WAIT_FS;
            end
            WAIT_FS: begin
                if (!VSYNC) begin
                    if (EN) begin
                        state_next     = CAPTURE;
                        mode_next      = MODE;
                        x_next         = '0;
                        y_next         = '0;
                        phase_next     = PHASE_HI;
                        href_prev_next = 1'b0;
                    end else begin
                        state_next = WAIT_VS;
                    end
                end
            end
            CAPTURE: begin
                if (VSYNC) begin
                    // VSYNC wins over HREF: close the frame, ignore any line data
                    state_next     = WAIT_FS;
                    phase_next     = PHASE_HI;
                    href_prev_next = 1'b0;
                    if (y_reg == Y_MAX) begin
                        done_next   = 1'b1;
                        fcount_next = fcount_reg + FCNT_W'(1);
                    end else begin
                        set_bits[2] = 1'b1;
                    end
                end else begin
                    href_prev_next = HREF;
                    if (HREF) begin
                        if (phase_reg == PHASE_HI) begin
                            hi_next    = {DATA[7:5], DATA[3:0]};
                            phase_next = PHASE_LO;
                        end else begin
                            phase_next = PHASE_HI;
                            if (x_reg < X_MAX && y_reg < Y_MAX) begin
                                pixel_next = pix_conv;
                                addr_next  = addr_calc;
                                wen_next   = 1'b1;
                            end else begin
                                set_bits[1] = 1'b1;
                            end
                            if (x_reg < X_MAX) x_next = x_reg + X_W'(1);
                        end
                    end else if (href_prev_reg) begin
                        x_next     = '0;
                        phase_next = PHASE_HI;
                        if (y_reg < Y_MAX) y_next = y_reg + Y_W'(1);
                        if (phase_reg == PHASE_LO) set_bits[0] = 1'b1;
                    end
                end
            end
            default: state_next = WAIT_VS;
        endcase

        // A set event coinciding with CLEAR survives the clear
        status_next = (CLEAR ? 3'b000 : status_reg) | set_bits;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg     <= WAIT_VS;
            mode_reg      <= 2'd0;
            x_reg         <= '0;
            y_reg         <= '0;
            phase_reg     <= PHASE_HI;
            hi_reg        <= '0;
            href_prev_reg <= 1'b0;
            pixel_reg     <= '0;
            addr_reg      <= '0;
            wen_reg       <= 1'b0;
            done_reg      <= 1'b0;
            fcount_reg    <= '0;
            status_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            mode_reg      <= mode_next;
            x_reg         <= x_next;
            y_reg         <= y_next;
            phase_reg     <= phase_next;
            hi_reg        <= hi_next;
            href_prev_reg <= href_prev_next;
            pixel_reg     <= pixel_next;
            addr_reg      <= addr_next;
            wen_reg       <= wen_next;
            done_reg      <= done_next;
            fcount_reg    <= fcount_next;
            status_reg    <= status_next;
        end
    end

    assign PIXEL_OUT   = pixel_reg;
    assign W_ADDR      = addr_reg;
    assign W_EN        = wen_reg;
    assign FRAME_DONE  = done_reg;
    assign FRAME_COUNT = fcount_reg;
    assign STATUS      = status_reg;

endmodule

// File: tb/tb_ov7670_frame_capture.sv
// Scoreboard bench for ov7670_frame_capture: line tasks queue expected {addr,pixel} writes,
// a forked monitor pops and compares on every W_EN; directed checks cover status and counters.
module tb_ov7670_frame_capture;

    localparam int W = 176;
    localparam int H = 144;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [1:0]  mode;
    logic        vsync;
    logic        href;
    logic [7:0]  data;
    logic        clear;
    logic [7:0]  pixel_out;
    logic [14:0] w_addr;
    logic        w_en;
    logic        frame_done;
    logic [3:0]  frame_count;
    logic [2:0]  status;

    int checks;
    int failures;
    int write_count;
    int done_seen;
    int last_addr;
    int cur_y;
    bit capturing;
    logic [31:0] exp_q[$];

    ov7670_frame_capture #(
        .SCREEN_WIDTH (W),
        .SCREEN_HEIGHT(H),
        .ADDR_W       (15),
        .FCNT_W       (4)
    ) dut (
        .CLK        (clk),
        .RESET_N    (rst_n),
        .EN         (en),
        .MODE       (mode),
        .VSYNC      (vsync),
        .HREF       (href),
        .DATA       (data),
        .CLEAR      (clear),
        .PIXEL_OUT  (pixel_out),
        .W_ADDR     (w_addr),
        .W_EN       (w_en),
        .FRAME_DONE (frame_done),
        .FRAME_COUNT(frame_count),
        .STATUS     (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic monitor;
        logic [31:0] exp_v;
        forever begin
            @(negedge clk);
            if (w_en === 1'b1) begin
                write_count++;
                last_addr = int'(w_addr);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {9'd0, w_addr, pixel_out}, 32'hFFFF_FFFF);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("write", {9'd0, w_addr, pixel_out}, exp_v);
                end
            end
            if (frame_done === 1'b1) done_seen++;
        end
    endtask

    function automatic logic [7:0] bar_pix(input int x);
        if (x < 58)  return 8'hE0;
        if (x < 117) return 8'h1C;
        return 8'h03;
    endfunction

    task automatic begin_frame;
        vsync = 1'b1; tick;
        vsync = 1'b0; tick;
        cur_y = 0;
    endtask

    task automatic end_frame;
        vsync = 1'b1; tick; tick;
    endtask

    task automatic send_line(input int nbytes, input logic [7:0] hi, input logic [7:0] lo,
                             input logic [7:0] exp_pix, input bit bars);
        int k;
        logic [7:0] p;
        for (int i = 0; i < nbytes; i++) begin
            href = 1'b1;
            data = (i % 2 == 0) ? hi : lo;
            k = i / 2;
            if (i % 2 == 1 && capturing && k < W && cur_y < H) begin
                p = bars ? bar_pix(k) : exp_pix;
                exp_q.push_back({9'd0, 15'(k + cur_y * W), p});
            end
            tick;
        end
        href = 1'b0;
        data = 8'h00;
        tick; tick;
        cur_y++;
    endtask

    task automatic pulse_clear;
        clear = 1'b1; tick;
        clear = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0; write_count = 0; done_seen = 0; last_addr = -1;
        cur_y = 0; capturing = 1'b1;
        rst_n = 1'b0; en = 1'b1; mode = 2'd0; vsync = 1'b0; href = 1'b0;
        data = 8'h00; clear = 1'b0;
        fork
            monitor();
        join_none

        tick; tick; tick;
        check("rst_pixel", {24'd0, pixel_out}, 32'd0);
        check("rst_addr", {17'd0, w_addr}, 32'd0);
        check("rst_wen", {31'd0, w_en}, 32'd0);
        check("rst_done", {31'd0, frame_done}, 32'd0);
        check("rst_count", {28'd0, frame_count}, 32'd0);
        check("rst_status", {29'd0, status}, 32'd0);
        rst_n = 1'b1;
        tick;

        // Full RGB565 frame, every pixel F8/00 -> E0
        mode = 2'd0;
        begin_frame;
        for (int y = 0; y < H; y++) send_line(2 * W, 8'hF8, 8'h00, 8'hE0, 1'b0);
        end_frame;
        check("t1_writes", write_count, 25344);
        check("t1_last_addr", last_addr, 25343);
        check("t1_done", done_seen, 1);
        check("t1_count", {28'd0, frame_count}, 1);
        check("t1_status", {29'd0, status}, 0);
        check("t1_queue", exp_q.size(), 0);

        // RGB444, 180-pixel lines clip at 176 writes
        mode = 2'd1;
        write_count = 0;
        begin_frame;
        for (int y = 0; y < 3; y++) send_line(360, 8'h0F, 8'hF0, 8'hFC, 1'b0);
        check("t2_writes", write_count, 3 * W);
        check("t2_clip", {29'd0, status}, 32'b010);
        end_frame;
        check("t2_abort_clip", {29'd0, status}, 32'b110);
        check("t2_count", {28'd0, frame_count}, 1);
        pulse_clear;
        tick;
        check("t2_clear", {29'd0, status}, 0);

        // Odd byte: 3 bytes give one write at X=0, next line at SCREEN_WIDTH
        mode = 2'd0;
        begin_frame;
        send_line(3, 8'hF8, 8'h00, 8'hE0, 1'b0);
        check("t3_odd", {29'd0, status}, 32'b001);
        send_line(4, 8'hF8, 8'h00, 8'hE0, 1'b0);
        check("t3_next_line_addr", last_addr, W + 1);
        end_frame;
        pulse_clear;

        // Short frame of 100 lines aborts, then a full frame completes
        begin_frame;
        for (int y = 0; y < 100; y++) send_line(2, 8'hF8, 8'h00, 8'hE0, 1'b0);
        end_frame;
        check("t4_abort", {29'd0, status}, 32'b100);
        check("t4_no_done", done_seen, 1);
        check("t4_count_hold", {28'd0, frame_count}, 1);
        pulse_clear;
        begin_frame;
        for (int y = 0; y < H; y++) send_line(2, 8'hF8, 8'h00, 8'hE0, 1'b0);
        end_frame;
        check("t4_done", done_seen, 2);
        check("t4_count", {28'd0, frame_count}, 2);
        check("t4_status", {29'd0, status}, 0);

        // Test bars, then enough frames to wrap the 4-bit counter
        mode = 2'd2;
        begin_frame;
        send_line(2 * 118, 8'h55, 8'hAA, 8'h00, 1'b1);
        for (int y = 1; y < H; y++) send_line(2, 8'h55, 8'hAA, 8'h00, 1'b1);
        end_frame;
        check("t5_count3", {28'd0, frame_count}, 3);
        for (int f = 0; f < 13; f++) begin
            begin_frame;
            for (int y = 0; y < H; y++) send_line(2, 8'h00, 8'h00, 8'h00, 1'b1);
            end_frame;
        end
        check("t5_count_wrap0", {28'd0, frame_count}, 0);
        begin_frame;
        for (int y = 0; y < H; y++) send_line(2, 8'h00, 8'h00, 8'h00, 1'b1);
        end_frame;
        check("t5_count_wrap1", {28'd0, frame_count}, 1);
        check("t5_done", done_seen, 17);
        check("t5_queue", exp_q.size(), 0);

        // EN=0 at frame start: no writes in that frame
        mode = 2'd0;
        en = 1'b0;
        capturing = 1'b0;
        write_count = 0;
        begin_frame;
        for (int y = 0; y < 4; y++) send_line(8, 8'hF8, 8'h00, 8'hE0, 1'b0);
        end_frame;
        check("t6_en0_writes", write_count, 0);
        check("t6_en0_status", {29'd0, status}, 0);
        check("t6_en0_count", {28'd0, frame_count}, 1);
        en = 1'b1;
        capturing = 1'b1;

        // Reset mid-line drops the in-flight write immediately
        begin_frame;
        href = 1'b1; data = 8'hF8; tick;
        data = 8'h00; tick;
        check("t6_wen_before_rst", {31'd0, w_en}, 1);
        rst_n = 1'b0;
        #1;
        check("t6_wen_in_rst", {31'd0, w_en}, 0);
        check("t6_count_in_rst", {28'd0, frame_count}, 0);
        check("t6_addr_in_rst", {17'd0, w_addr}, 0);
        href = 1'b0;
        tick; tick;
        rst_n = 1'b1;
        tick; tick;
        check("final_queue", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
